// File: rtl/counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : counter_unit
// Description : Parameterised synchronous up/down binary counter with
//               enable, synchronous clear and parallel load. Provides a
//               registered count, a registered one-cycle wrap pulse and a
//               combinational limit flag. Single clock domain.
// Config      : COUNTER_UNIT_SATURATE_EN
//                 defined   - an enabled step at the limit holds the count
//                             and wrap is tied low.
//                 undefined - modulo wrap-around; wrap pulses on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_unit #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] C_MAX  = '1;
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  // --------------------------------------------------------------------------
  // Limit detection
  // --------------------------------------------------------------------------
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_step;

  assign w_at_max   = (count_q == C_MAX);
  assign w_at_zero  = (count_q == C_ZERO);
  // The limit is direction-relative: the next enabled step would wrap.
  assign w_at_limit = up_dn ? w_at_max : w_at_zero;
  // Unsigned modulo step in the currently sampled direction.
  assign w_step     = up_dn ? (count_q + C_ONE) : (count_q - C_ONE);

  // Next-state selection: clr > load > enable > hold (rst handled in the flop).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = C_ZERO;
    end else if (load) begin
      count_d = load_val;
    end else if (enable) begin
`ifdef COUNTER_UNIT_SATURATE_EN
      // Saturating build: refuse to step past the limit, never pulse wrap.
      if (!w_at_limit) begin
        count_d = w_step;
      end
`else
      // Modulo build: always step; a step taken from the limit is a wrap.
      count_d = w_step;
      wrap_d  = w_at_limit;
`endif
    end
  end

  // Register count and wrap; synchronous reset overrides all other controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_limit = w_at_limit;

endmodule
`default_nettype wire

// File: tb/tb_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_unit
// Description : Directed self-checking bench for counter_unit (WIDTH=8,
//               RESET_VAL=0). Expected values are hand-computed; the
//               saturating build is selected by COUNTER_UNIT_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_unit;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       wrap;
  logic       at_limit;

  int total;
  int bad;

  counter_unit #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .at_limit (at_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns so outputs are sampled off-edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'hAA;
    tick(2);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count actual=%h expected=%h", count, 8'h00); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap actual=%b expected=%b", wrap, 1'b0); end
    rst = 1'b0; enable = 1'b0; up_dn = 1'b0;
    tick(2);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL idle_hold actual=%h expected=%h", count, 8'h00); end
    total++; if (at_limit !== 1'b1) begin bad++; $display("FAIL limit_zero_down actual=%b expected=%b", at_limit, 1'b1); end
  endtask

  task automatic test_count_up;
    enable = 1'b1; up_dn = 1'b1;
    tick(5);
    total++; if (count !== 8'd5) begin bad++; $display("FAIL up5 actual=%h expected=%h", count, 8'd5); end
    enable = 1'b0;
    tick(2);
    total++; if (count !== 8'd5) begin bad++; $display("FAIL hold5 actual=%h expected=%h", count, 8'd5); end
    enable = 1'b1;
    tick(5);
    total++; if (count !== 8'd10) begin bad++; $display("FAIL up10 actual=%h expected=%h", count, 8'd10); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up10_wrap actual=%b expected=%b", wrap, 1'b0); end
    enable = 1'b0;
  endtask

  task automatic test_wrap_up;
    load = 1'b1; load_val = 8'hFE; up_dn = 1'b1;
    tick(1);
    load = 1'b0;
    total++; if (count !== 8'hFE) begin bad++; $display("FAIL load_fe actual=%h expected=%h", count, 8'hFE); end
    total++; if (at_limit !== 1'b0) begin bad++; $display("FAIL limit_fe actual=%b expected=%b", at_limit, 1'b0); end
    enable = 1'b1;
    tick(1);
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL step_ff actual=%h expected=%h", count, 8'hFF); end
    total++; if (at_limit !== 1'b1) begin bad++; $display("FAIL limit_ff actual=%b expected=%b", at_limit, 1'b1); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_pre actual=%b expected=%b", wrap, 1'b0); end
    tick(1);
`ifdef COUNTER_UNIT_SATURATE_EN
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL sat_up actual=%h expected=%h", count, 8'hFF); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL sat_up_wrap actual=%b expected=%b", wrap, 1'b0); end
`else
    total++; if (count !== 8'h00) begin bad++; $display("FAIL wrap_up actual=%h expected=%h", count, 8'h00); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL wrap_up_pulse actual=%b expected=%b", wrap, 1'b1); end
`endif
    enable = 1'b0;
    tick(1);
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_up_clear actual=%b expected=%b", wrap, 1'b0); end
  endtask

  task automatic test_wrap_down;
    load = 1'b1; load_val = 8'h00;
    tick(1);
    load = 1'b0; up_dn = 1'b0; enable = 1'b1;
    tick(1);
`ifdef COUNTER_UNIT_SATURATE_EN
    total++; if (count !== 8'h00) begin bad++; $display("FAIL sat_down actual=%h expected=%h", count, 8'h00); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL sat_down_wrap actual=%b expected=%b", wrap, 1'b0); end
    tick(1);
    total++; if (count !== 8'h00) begin bad++; $display("FAIL sat_down2 actual=%h expected=%h", count, 8'h00); end
`else
    total++; if (count !== 8'hFF) begin bad++; $display("FAIL wrap_down actual=%h expected=%h", count, 8'hFF); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL wrap_down_pulse actual=%b expected=%b", wrap, 1'b1); end
    tick(1);
    total++; if (count !== 8'hFE) begin bad++; $display("FAIL down_fe actual=%h expected=%h", count, 8'hFE); end
`endif
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_down_clear actual=%b expected=%b", wrap, 1'b0); end
    enable = 1'b0;
  endtask

  task automatic test_rst_and_clr;
    load = 1'b1; load_val = 8'h36;
    tick(1);
    load = 1'b0; enable = 1'b1; up_dn = 1'b1;
    tick(1);
    total++; if (count !== 8'h37) begin bad++; $display("FAIL mid_37 actual=%h expected=%h", count, 8'h37); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0; enable = 1'b0;
    total++; if (count !== 8'h00) begin bad++; $display("FAIL mid_rst actual=%h expected=%h", count, 8'h00); end
    enable = 1'b1;
    tick(1);
    total++; if (count !== 8'h01) begin bad++; $display("FAIL post_rst_step actual=%h expected=%h", count, 8'h01); end
    enable = 1'b0; load = 1'b1; load_val = 8'h20;
    tick(1);
    load_val = 8'h55; clr = 1'b1; enable = 1'b1;
    tick(1);
    clr = 1'b0; load = 1'b0; enable = 1'b0;
    total++; if (count !== 8'h00) begin bad++; $display("FAIL clr_over_load actual=%h expected=%h", count, 8'h00); end
  endtask

  task automatic test_load_enable;
    load = 1'b1; enable = 1'b1; up_dn = 1'b1; load_val = 8'h10;
    tick(1);
    load = 1'b0;
    total++; if (count !== 8'h10) begin bad++; $display("FAIL load_en actual=%h expected=%h", count, 8'h10); end
    tick(1);
    total++; if (count !== 8'h11) begin bad++; $display("FAIL load_then_up actual=%h expected=%h", count, 8'h11); end
    up_dn = 1'b0;
    tick(1);
    total++; if (count !== 8'h10) begin bad++; $display("FAIL dir_change actual=%h expected=%h", count, 8'h10); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0; enable = 1'b0;
    total++; if (count !== 8'h00) begin bad++; $display("FAIL clr_with_en actual=%h expected=%h", count, 8'h00); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; enable = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_rst_and_clr();
    test_load_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
